// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
// The phase lookup is used by each axis counter to derive its next phase.
package vga_timing_pkg;

  localparam int unsigned CountW = 10;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFront  = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBack   = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFront  = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBack   = 33;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } axis_phase_t;

  // Registered output bundle; one flop set keeps every output on the same edge.
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       frame_active;
    logic       h_sync;
    logic       v_sync;
    logic       line_start;
    logic       frame_start;
  } vga_out_t;

  function automatic axis_phase_t count_phase(input logic [CountW-1:0] count,
                                              input int unsigned active,
                                              input int unsigned front,
                                              input int unsigned sync);
    int unsigned c;
    c = 32'(count);
    if (c < active) begin
      return PH_ACTIVE;
    end else if (c < active + front) begin
      return PH_FRONT;
    end else if (c < active + front + sync) begin
      return PH_SYNC;
    end
    return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase register.
// wrap is combinational so the vertical axis can step on the same edge.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE   = DefHActive,
  parameter int unsigned FRONT    = DefHFront,
  parameter int unsigned SYNC     = DefHSync,
  parameter int unsigned BACK     = DefHBack,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [CountW-1:0] count,
  output axis_phase_t       phase,
  output logic              wrap,
  output logic              sync
);

  localparam int unsigned       Total     = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [CountW-1:0] LastCount = CountW'(Total - 1);

  logic [CountW-1:0] count_d, count_q;
  axis_phase_t       phase_d, phase_q;

  assign wrap = step && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + CountW'(1);
    end
  end

  // Phase follows the count it is about to hold, so it stays aligned with count_q.
  always_comb begin
    phase_d = phase_q;
    if (step) begin
      phase_d = count_phase(count_d, ACTIVE, FRONT, SYNC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  assign sync  = (phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: horizontal and vertical axis counters with all
// outputs registered one enabled cycle behind the counter state they decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FRONT  = DefHFront,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BACK   = DefHBack,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FRONT  = DefVFront,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BACK   = DefVBack,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       frame_active,
  output logic       h_sync,
  output logic       v_sync,
  output logic       line_start,
  output logic       frame_start
);

  logic [CountW-1:0] h_count, v_count;
  axis_phase_t       h_phase, v_phase;
  logic              h_wrap, v_wrap;
  logic              h_sync_lvl, v_sync_lvl;
  logic              v_step;

  assign v_step = ena & h_wrap;

  sync_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (ena),
    .count (h_count),
    .phase (h_phase),
    .wrap  (h_wrap),
    .sync  (h_sync_lvl)
  );

  sync_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (v_step),
    .count (v_count),
    .phase (v_phase),
    .wrap  (v_wrap),
    .sync  (v_sync_lvl)
  );

  vga_out_t out_d, out_q, out_rst;

  always_comb begin
    out_rst              = '0;
    out_rst.h_sync       = ~SYNC_POL;
    out_rst.v_sync       = ~SYNC_POL;
  end

  always_comb begin
    out_d = out_q;
    if (ena) begin
      out_d.x            = h_count[9:0];
      out_d.y            = v_count[8:0];
      out_d.frame_active = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      out_d.h_sync       = h_sync_lvl;
      out_d.v_sync       = v_sync_lvl;
      out_d.line_start   = (h_count == '0);
      out_d.frame_start  = (h_count == '0) && (v_count == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= out_rst;
    end else begin
      out_q <= out_d;
    end
  end

  assign x            = out_q.x;
  assign y            = out_q.y;
  assign frame_active = out_q.frame_active;
  assign h_sync       = out_q.h_sync;
  assign v_sync       = out_q.v_sync;
  assign line_start   = out_q.line_start;
  assign frame_start  = out_q.frame_start;

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, a tiny
// SYNC_POL=1 instance for frame wrap, ena gating and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ena_a, rst_b, ena_b;
  logic [9:0] x_a, x_b;
  logic [8:0] y_a, y_b;
  logic       fa_a, hs_a, vs_a, ls_a, fs_a;
  logic       fa_b, hs_b, vs_b, ls_b, fs_b;
  logic [23:0] obs_a, obs_b;

  assign obs_a = {x_a, y_a, fa_a, hs_a, vs_a, ls_a, fs_a};
  assign obs_b = {x_b, y_b, fa_b, hs_b, vs_b, ls_b, fs_b};

  localparam logic [23:0] ResetA = {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] ResetB = 24'd0;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen dut_a (
    .clk (clk), .rst (rst_a), .ena (ena_a), .x (x_a), .y (y_a), .frame_active (fa_a),
    .h_sync (hs_a), .v_sync (vs_a), .line_start (ls_a), .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1), .SYNC_POL (1'b1)
  ) dut_b (
    .clk (clk), .rst (rst_b), .ena (ena_b), .x (x_b), .y (y_b), .frame_active (fa_b),
    .h_sync (hs_b), .v_sync (vs_b), .line_start (ls_b), .frame_start (fs_b)
  );

  // Expected outputs k enabled cycles after the first post-reset enabled edge.
  function automatic logic [23:0] exp_a(input int unsigned k);
    int unsigned hx = k % 800;
    int unsigned ln = (k / 800) % 525;
    return {10'(hx), 9'(ln), (hx < 640 && ln < 480), !(hx >= 656 && hx < 752),
            !(ln >= 490 && ln < 492), (hx == 0), (hx == 0 && ln == 0)};
  endfunction

  function automatic logic [23:0] exp_b(input int unsigned k);
    int unsigned hx = k % 8;
    int unsigned ln = (k / 8) % 6;
    return {10'(hx), 9'(ln), (hx < 4 && ln < 3), (hx == 5 || hx == 6), (ln == 4),
            (hx == 0), (hx == 0 && ln == 0)};
  endfunction

  task automatic test_reset();
    rst_a = 1'b1; ena_a = 1'b1; rst_b = 1'b1; ena_b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs_a !== ResetA) begin
      n_bad++; $display("FAIL reset_a: got %h want %h", obs_a, ResetA);
    end
    n_cmp++;
    if (obs_b !== ResetB) begin
      n_bad++; $display("FAIL reset_b: got %h want %h", obs_b, ResetB);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_a !== exp_a(0)) begin
      n_bad++; $display("FAIL first_edge_a: got %h want %h", obs_a, exp_a(0));
    end
    n_cmp++;
    if (obs_b !== exp_b(0)) begin
      n_bad++; $display("FAIL first_edge_b: got %h want %h", obs_b, exp_b(0));
    end
  endtask

  task automatic test_lines();
    int bad = 0, first_k = -1, ls_cnt = 0, ls_second = -1, hs_low = 0, hs_first = -1;
    int run = 0, run_max = 0, fa_cnt = 0;
    logic [23:0] bad_obs = '0, bad_exp = '0;
    rst_a = 1'b1; ena_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      if (obs_a !== exp_a(k)) begin
        if (bad == 0) begin first_k = k; bad_obs = obs_a; bad_exp = exp_a(k); end
        bad++;
      end
      if (ls_a) begin ls_cnt++; if (k != 0 && ls_second < 0) ls_second = k; end
      if (!hs_a) begin
        hs_low++; run++; if (hs_first < 0) hs_first = k;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
      if (fa_a) fa_cnt++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL line_trace: %0d bad cycles, first k=%0d got %h want %h",
               bad, first_k, bad_obs, bad_exp);
    end
    n_cmp++;
    if (ls_second !== 800) begin
      n_bad++; $display("FAIL line_period: got %0d want 800", ls_second);
    end
    n_cmp++;
    if (hs_first !== 656) begin
      n_bad++; $display("FAIL hsync_start: got %0d want 656", hs_first);
    end
    n_cmp++;
    if (run_max !== 96 || hs_low !== 192) begin
      n_bad++; $display("FAIL hsync_width: run %0d total %0d want 96/192", run_max, hs_low);
    end
    n_cmp++;
    if (fa_cnt !== 1280) begin
      n_bad++; $display("FAIL active_count: got %0d want 1280", fa_cnt);
    end
  endtask

  task automatic test_small_frame();
    int bad = 0, first_k = -1, fs_first = -1, fs_second = -1, vs_hi = 0, hs_hi = 0;
    logic [23:0] bad_obs = '0, bad_exp = '0;
    logic corner_ok = 1'b0;
    rst_b = 1'b1; ena_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      if (obs_b !== exp_b(k)) begin
        if (bad == 0) begin first_k = k; bad_obs = obs_b; bad_exp = exp_b(k); end
        bad++;
      end
      if (fs_b) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (vs_b) vs_hi++;
      if (hs_b) hs_hi++;
      if (k == 48) corner_ok = ls_b && fs_b && (x_b == 10'd0) && (y_b == 9'd0);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL small_trace: %0d bad cycles, first k=%0d got %h want %h",
               bad, first_k, bad_obs, bad_exp);
    end
    n_cmp++;
    if (fs_second - fs_first !== 48) begin
      n_bad++; $display("FAIL frame_period: got %0d want 48", fs_second - fs_first);
    end
    n_cmp++;
    if (vs_hi !== 16) begin
      n_bad++; $display("FAIL vsync_width: got %0d want 16 over two frames", vs_hi);
    end
    n_cmp++;
    if (hs_hi !== 24) begin
      n_bad++; $display("FAIL small_hsync: got %0d want 24 over twelve lines", hs_hi);
    end
    n_cmp++;
    if (corner_ok !== 1'b1) begin
      n_bad++; $display("FAIL corner_wrap: got %b want 1", corner_ok);
    end
  endtask

  task automatic test_ena_toggle();
    logic [3:0] pat = 4'b1001;
    int e = 0, bad = 0, first_j = -1, fs_en = 0;
    logic [23:0] want, bad_obs = '0, bad_exp = '0;
    rst_b = 1'b1; ena_b = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_b !== ResetB) begin
      n_bad++; $display("FAIL rst_over_ena: got %h want %h", obs_b, ResetB);
    end
    rst_b = 1'b0;
    for (int j = 0; j < 200; j++) begin
      ena_b = pat[j % 4];
      @(posedge clk);
      if (ena_b) e++;
      @(negedge clk);
      want = (e == 0) ? ResetB : exp_b(e - 1);
      if (obs_b !== want) begin
        if (bad == 0) begin first_j = j; bad_obs = obs_b; bad_exp = want; end
        bad++;
      end
      if (ena_b && fs_b) fs_en++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL ena_gating: %0d bad cycles, first j=%0d got %h want %h",
               bad, first_j, bad_obs, bad_exp);
    end
    n_cmp++;
    if (fs_en !== 3) begin
      n_bad++; $display("FAIL ena_frame_count: got %0d want 3", fs_en);
    end
    ena_b = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic found = 1'b0;
    rst_a = 1'b1; ena_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge clk);
      if (x_a == 10'd300) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_bad++; $display("FAIL reach_x300: got %b want 1", found);
    end
    rst_a = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_a !== ResetA) begin
      n_bad++; $display("FAIL mid_reset_a: got %h want %h", obs_a, ResetA);
    end
    rst_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_a !== exp_a(0)) begin
      n_bad++; $display("FAIL restart_a: got %h want %h", obs_a, exp_a(0));
    end

    // Small instance: reset at x=4, y=2, in the vertical active region.
    rst_b = 1'b1; ena_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (21) @(negedge clk);
    n_cmp++;
    if (obs_b !== exp_b(20)) begin
      n_bad++; $display("FAIL pre_reset_b: got %h want %h", obs_b, exp_b(20));
    end
    rst_b = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_b !== ResetB) begin
      n_bad++; $display("FAIL mid_reset_b: got %h want %h", obs_b, ResetB);
    end
    rst_b = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_b !== exp_b(0)) begin
      n_bad++; $display("FAIL restart_b: got %h want %h", obs_b, exp_b(0));
    end
    @(negedge clk);
    n_cmp++;
    if (obs_b !== exp_b(1)) begin
      n_bad++; $display("FAIL restart_b_next: got %h want %h", obs_b, exp_b(1));
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_small_frame();
    test_ena_toggle();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
